// File: rtl/mram_access_arbiter_if.sv
// Requester-side handshake bundle for mram_access_arbiter: two command ports
// plus shared grant/done/read-data/busy returns.
interface mram_access_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              req0, req1;
  logic              we0, we1;
  logic [1:0]        be0, be1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              done0, done1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, we0, we1, be0, be1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, be0, be1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata, busy
  );
endinterface

// File: rtl/mram_access_arbiter.sv
// Two-port arbiter/sequencer for an asynchronous 16-bit MRAM (IDLE/SETUP/ACCESS/RECOVER).
// Define MRAM_ARB_FIXED_PRIO_EN for strict port-0 priority instead of round-robin.
module mram_access_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int T_SETUP = 1,
  parameter int T_WR    = 10,
  parameter int T_RD    = 5,
  parameter int T_REC   = 2
) (
  input  logic                FPGA_clk,
  input  logic                FPGA_rst_n,
  mram_access_arbiter_if.slave rq,
  output logic                chip_en_out,
  output logic                read_en_out,
  output logic                write_en_out,
  output logic                lb_en_out,
  output logic                ub_en_out,
  output logic [ADDR_W-1:0]   addr_line,
  output logic [DATA_W-1:0]   data_line,
  output logic                data_oe,
  input  logic [DATA_W-1:0]   data_in
);
  localparam int T_M1  = (T_SETUP > T_WR) ? T_SETUP : T_WR;
  localparam int T_M2  = (T_RD > T_REC) ? T_RD : T_REC;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CNT_W = $clog2(T_MAX) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              own_q, own_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              gnt0_d, gnt1_d, done0_d, done1_d, cap_d;
  logic              act_d;
  logic              pick1;

`ifdef MRAM_ARB_FIXED_PRIO_EN
  assign pick1 = !rq.req0;
`else
  // last_q == 1 means port 1 was served last, so port 0 wins the next tie
  logic last_q;
  assign pick1 = rq.req1 && (!rq.req0 || !last_q);

  always_ff @(posedge FPGA_clk or negedge FPGA_rst_n)
    if (!FPGA_rst_n)                                   last_q <= 1'b1;
    else if (state_q == IDLE && (rq.req0 || rq.req1)) last_q <= pick1;
`endif

  assign rq.busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_line;
    wdata_d = data_line;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    cap_d   = 1'b0;
    unique case (state_q)
      IDLE: if (rq.req0 || rq.req1) begin
        state_d = SETUP;
        cnt_d   = CNT_W'(T_SETUP - 1);
        own_d   = pick1;
        gnt0_d  = !pick1;
        gnt1_d  = pick1;
        we_d    = pick1 ? rq.we1    : rq.we0;
        be_d    = pick1 ? rq.be1    : rq.be0;
        addr_d  = pick1 ? rq.addr1  : rq.addr0;
        wdata_d = pick1 ? rq.wdata1 : rq.wdata0;
      end
      SETUP: if (cnt_q == '0) begin
        state_d = ACCESS;
        cnt_d   = we_q ? CNT_W'(T_WR - 1) : CNT_W'(T_RD - 1);
      end else cnt_d = cnt_q - CNT_W'(1);
      ACCESS: if (cnt_q == '0) begin
        state_d = RECOVER;
        cnt_d   = CNT_W'(T_REC - 1);
        done0_d = !own_q;
        done1_d = own_q;
        cap_d   = !we_q;
      end else cnt_d = cnt_q - CNT_W'(1);
      RECOVER: if (cnt_q == '0) state_d = IDLE;
               else              cnt_d   = cnt_q - CNT_W'(1);
      default: state_d = IDLE;
    endcase
    act_d = (state_d == SETUP) || (state_d == ACCESS);
  end

  // Strobes are registered from the next state so the pads see glitch-free edges
  always_ff @(posedge FPGA_clk or negedge FPGA_rst_n)
    if (!FPGA_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      own_q        <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= 2'b00;
      addr_line    <= '0;
      data_line    <= '0;
      rq.gnt0      <= 1'b0;
      rq.gnt1      <= 1'b0;
      rq.done0     <= 1'b0;
      rq.done1     <= 1'b0;
      rq.rdata     <= '0;
      chip_en_out  <= 1'b1;
      read_en_out  <= 1'b1;
      write_en_out <= 1'b1;
      lb_en_out    <= 1'b1;
      ub_en_out    <= 1'b1;
      data_oe      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      own_q        <= own_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_line    <= addr_d;
      data_line    <= wdata_d;
      rq.gnt0      <= gnt0_d;
      rq.gnt1      <= gnt1_d;
      rq.done0     <= done0_d;
      rq.done1     <= done1_d;
      if (cap_d) rq.rdata <= data_in;
      chip_en_out  <= !act_d;
      read_en_out  <= !(state_d == ACCESS && !we_d);
      write_en_out <= !(state_d == ACCESS && we_d);
      lb_en_out    <= !(act_d && be_d[0]);
      ub_en_out    <= !(act_d && be_d[1]);
      data_oe      <= act_d && we_d;
    end
endmodule
